// File: rtl/pc_seq_if.sv
// Fetch-side bundle between the control decoder, the program counter and the instruction ROM.
// The decoder drives the controls and LUT writes; the pc and status flags come back from the sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 10,
    parameter int IMM_W  = 5
);
    logic              stall;
    logic              branch;
    logic              flag;
    logic              call;
    logic              ret;
    logic [IMM_W-1:0]  imm;
    logic              lut_we;
    logic [IMM_W-1:0]  lut_waddr;
    logic [ADDR_W-1:0] lut_wdata;
    logic [ADDR_W-1:0] pc;
    logic              halt;
    logic              stack_err;

    modport master (
        output stall, branch, flag, call, ret, imm, lut_we, lut_waddr, lut_wdata,
        input  pc, halt, stack_err
    );

    modport slave (
        input  stall, branch, flag, call, ret, imm, lut_we, lut_waddr, lut_wdata,
        output pc, halt, stack_err
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter with relative/LUT branching, a call/return stack, fetch stall and
// per-program halt address. All outputs are registers; controls take effect at the next edge.
module pc_seq #(
    parameter int ADDR_W      = 10,
    parameter int IMM_W       = 5,
    parameter int STACK_DEPTH = 4,
    parameter int SPLIT_ADDR  = 50,
    parameter int PROG1_BASE  = 65,
    parameter int END0        = 63,
    parameter int END1        = 1023
) (
    input  logic     clk,
    input  logic     start_n,
    pc_seq_if.slave  bus
);
    localparam int LUT_D = 2 ** IMM_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] L_SPLIT = ADDR_W'(SPLIT_ADDR);
    localparam logic [ADDR_W-1:0] L_BASE1 = ADDR_W'(PROG1_BASE);
    localparam logic [ADDR_W-1:0] L_END0  = ADDR_W'(END0);
    localparam logic [ADDR_W-1:0] L_END1  = ADDR_W'(END1);

    logic [ADDR_W-1:0] r_lut   [0:LUT_D-1];
    logic [ADDR_W-1:0] r_stack [0:STACK_DEPTH-1];
    logic [SP_W-1:0]   r_sp;
    logic [ADDR_W-1:0] r_pc;
    logic              r_prog;
    logic              r_halt;
    logic              r_stack_err;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_imm_sext;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_lut_rd;
    logic [ADDR_W-1:0] w_stack_top;
    logic [ADDR_W-1:0] w_end_addr;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_at_end;
    logic              w_stack_full;
    logic              w_stack_empty;
    logic              w_active;
    logic              w_do_ret;
    logic              w_do_call;
    logic              w_push;
    logic              w_pop;
    logic              w_fault;

    assign w_pc_inc      = r_pc + ADDR_W'(1);
    assign w_imm_sext    = ADDR_W'($signed(bus.imm));
    assign w_br_tgt      = r_pc + w_imm_sext + ADDR_W'(1);
    // Async read: a same-edge write to this entry is not yet visible here.
    assign w_lut_rd      = r_lut[bus.imm];
    assign w_end_addr    = r_prog ? L_END1 : L_END0;
    assign w_at_end      = (r_pc == w_end_addr);

    assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stack_empty = (r_sp == '0);
    assign w_push_idx    = IDX_W'(r_sp);
    assign w_top_idx     = IDX_W'(r_sp - SP_W'(1));
    assign w_stack_top   = r_stack[w_top_idx];

    // ret outranks call; both are ignored while halted, stalled or sitting on the end address.
    assign w_active  = start_n & ~r_halt & ~w_at_end & ~bus.stall;
    assign w_do_ret  = w_active & bus.ret;
    assign w_do_call = w_active & ~bus.ret & bus.call;
    assign w_push    = w_do_call & ~w_stack_full;
    assign w_pop     = w_do_ret & ~w_stack_empty;
    assign w_fault   = (w_do_ret & w_stack_empty) | (w_do_call & w_stack_full);

    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!start_n) begin
            // Program selection looks at the pc from before the restart.
            r_prog      <= (r_pc >= L_SPLIT);
            r_pc        <= (r_pc >= L_SPLIT) ? L_BASE1 : '0;
            r_halt      <= 1'b0;
            r_stack_err <= 1'b0;
            r_sp        <= '0;
        end else if (!r_halt) begin
            if (w_at_end) begin
                r_halt <= 1'b1;
            end else if (w_fault) begin
                r_halt      <= 1'b1;
                r_stack_err <= 1'b1;
            end else if (w_pop) begin
                r_pc <= w_stack_top;
                r_sp <= r_sp - SP_W'(1);
            end else if (w_push) begin
                r_pc <= w_lut_rd;
                r_sp <= r_sp + SP_W'(1);
            end else if (!bus.stall) begin
                if (bus.branch) begin
                    r_pc <= bus.flag ? w_lut_rd : w_br_tgt;
                end else begin
                    r_pc <= w_pc_inc;
                end
            end
        end
    end

    assign bus.pc        = r_pc;
    assign bus.halt      = r_halt;
    assign bus.stack_err = r_stack_err;
endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus a randomized run, all
// compared against a queue/array based reference model of the sequencer.
module tb_pc_seq;
    logic clk = 1'b0;
    logic start_n;
    int   checks = 0;
    int   errors = 0;

    pc_seq_if #(.ADDR_W(10), .IMM_W(5)) bif();

    pc_seq u_dut (
        .clk     (clk),
        .start_n (start_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    int m_pc   = 0;
    bit m_halt = 0;
    bit m_err  = 0;
    bit m_prog = 0;
    int m_stack[$];
    int m_lut[32];

    // One clock: apply inputs, advance the model by the spec rules, then step the DUT.
    task automatic cyc(input bit rn, input bit st, input bit br, input bit fl, input bit ca,
                       input bit re, input int im, input bit we, input int wa, input int wd);
        int simm;
        start_n       = rn;
        bif.stall     = st;
        bif.branch    = br;
        bif.flag      = fl;
        bif.call      = ca;
        bif.ret       = re;
        bif.imm       = 5'(im);
        bif.lut_we    = we;
        bif.lut_waddr = 5'(wa);
        bif.lut_wdata = 10'(wd);
        simm = (im >= 16) ? im - 32 : im;
        if (!rn) begin
            m_prog = (m_pc >= 50);
            m_pc   = m_prog ? 65 : 0;
            m_halt = 0;
            m_err  = 0;
            m_stack.delete();
        end else if (m_halt) begin
        end else if (m_pc == (m_prog ? 1023 : 63)) begin
            m_halt = 1;
        end else if (st) begin
        end else if (re) begin
            if (m_stack.size() == 0) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (ca) begin
            if (m_stack.size() == 4) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_stack.push_back((m_pc + 1) % 1024);
                m_pc = m_lut[im];
            end
        end else if (br) begin
            m_pc = fl ? m_lut[im] : (((m_pc + simm + 1) % 1024) + 1024) % 1024;
        end else begin
            m_pc = (m_pc + 1) % 1024;
        end
        if (we) m_lut[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // LUT[0] permanently holds 5, giving a path from any base back to program 0.
    task automatic restart0();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 1, i, (i == 0) ? 5 : (i == 7) ? 200 : int'($urandom_range(1, 1023)));
        // Power-up pc is undefined, so the first restart may legitimately land on either base.
        if (bif.pc === 10'd65) begin m_pc = 65; m_prog = 1; end
        restart0();
        checks++;
        if (bif.pc !== 10'd0 || bif.halt !== 1'b0 || bif.stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%0d halt=%0b err=%0b, want pc=0 halt=0 err=0", bif.pc, bif.halt, bif.stack_err);
        end
        for (int i = 1; i <= 5; i++) begin
            idle();
            checks++;
            if (bif.pc !== 10'(i) || bif.pc !== 10'(m_pc) || bif.halt !== 1'b0) begin
                errors++;
                $display("FAIL reset_count: pc=%0d halt=%0b, want pc=%0d halt=0", bif.pc, bif.halt, i);
            end
        end
    endtask

    task automatic test_branch_rel();
        restart0();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 10);
        cyc(1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 5'b11101, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd8 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL branch_rel_neg: pc=%0d, want 8", bif.pc);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 2, 1023);
        cyc(1, 0, 1, 1, 0, 0, 2, 0, 0, 0);
        idle();
        checks++;
        if (bif.pc !== 10'd0 || bif.halt !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%0d halt=%0b, want pc=0 halt=0", bif.pc, bif.halt);
        end
        cyc(1, 0, 1, 0, 0, 0, 5'b10000, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd1009 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL branch_rel_wrap: pc=%0d, want 1009", bif.pc);
        end
    endtask

    task automatic test_lut_jump();
        restart0();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, 200);
        cyc(1, 0, 1, 1, 0, 0, 7, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd200 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL lut_jump: pc=%0d, want 200", bif.pc);
        end
        cyc(1, 0, 1, 1, 0, 0, 7, 1, 7, 300);
        checks++;
        if (bif.pc !== 10'd200) begin
            errors++;
            $display("FAIL lut_same_cycle_old: pc=%0d, want 200", bif.pc);
        end
        cyc(1, 0, 1, 1, 0, 0, 7, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd300 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL lut_new_value: pc=%0d, want 300", bif.pc);
        end
    endtask

    task automatic test_call_ret();
        restart0();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, (i == 0), 7, 200);
        cyc(1, 0, 1, 0, 1, 0, 7, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd200 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL call: pc=%0d, want 200", bif.pc);
        end
        cyc(1, 0, 0, 0, 1, 1, 7, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd6 || bif.stack_err !== 1'b0 || bif.halt !== 1'b0) begin
            errors++;
            $display("FAIL ret: pc=%0d err=%0b halt=%0b, want pc=6 err=0 halt=0", bif.pc, bif.stack_err, bif.halt);
        end
    endtask

    task automatic test_stack_errors();
        restart0();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        checks++;
        if (bif.stack_err !== 1'b1 || bif.halt !== 1'b1 || bif.pc !== 10'd200) begin
            errors++;
            $display("FAIL overflow: pc=%0d err=%0b halt=%0b, want pc=200 err=1 halt=1", bif.pc, bif.stack_err, bif.halt);
        end
        idle();
        cyc(1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd200 || bif.halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: pc=%0d halt=%0b, want pc=200 halt=1", bif.pc, bif.halt);
        end
        restart0();
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (bif.stack_err !== 1'b1 || bif.halt !== 1'b1 || bif.pc !== 10'd0) begin
            errors++;
            $display("FAIL underflow: pc=%0d err=%0b halt=%0b, want pc=0 err=1 halt=1", bif.pc, bif.stack_err, bif.halt);
        end
    endtask

    task automatic test_halt_stall();
        restart0();
        for (int i = 0; i < 20; i++) idle();
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 0, 7, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd20 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL stall_hold: pc=%0d, want 20", bif.pc);
        end
        for (int i = 0; i < 100 && bif.halt !== 1'b1; i++) idle();
        checks++;
        if (bif.halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halt=%0b pc=%0d, want halt=1 within 100 cycles", bif.halt, bif.pc);
        end
        idle();
        idle();
        checks++;
        if (bif.pc !== 10'd63 || bif.halt !== 1'b1 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL end0_halt: pc=%0d halt=%0b, want pc=63 halt=1", bif.pc, bif.halt);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd65 || bif.halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_63: pc=%0d halt=%0b, want pc=65 halt=0", bif.pc, bif.halt);
        end
    endtask

    task automatic test_prog1();
        restart0();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3, 70);
        cyc(1, 0, 1, 1, 0, 0, 3, 1, 4, 1023);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bif.pc !== 10'd65 || bif.pc !== 10'(m_pc)) begin
            errors++;
            $display("FAIL prog1_reset: pc=%0d, want 65", bif.pc);
        end
        cyc(1, 0, 1, 1, 0, 0, 4, 0, 0, 0);
        idle();
        idle();
        checks++;
        if (bif.pc !== 10'd1023 || bif.halt !== 1'b1) begin
            errors++;
            $display("FAIL end1_halt: pc=%0d halt=%0b, want pc=1023 halt=1", bif.pc, bif.halt);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        restart0();
        for (int n = 0; n < 600; n++) begin
            bit rn, st, br, fl, ca, re, we;
            rn = !(($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 3) == 0));
            st = ($urandom_range(0, 6) == 0);
            re = ($urandom_range(0, 9) == 0);
            ca = ($urandom_range(0, 7) == 0);
            br = ($urandom_range(0, 2) == 0);
            fl = $urandom_range(0, 1);
            we = ($urandom_range(0, 3) == 0);
            cyc(rn, st, br, fl, ca, re, $urandom_range(0, 31), we, $urandom_range(1, 31), $urandom_range(0, 1023));
            checks++;
            if (bif.pc !== 10'(m_pc) || bif.halt !== m_halt || bif.stack_err !== m_err) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: pc=%0d halt=%0b err=%0b, want pc=%0d halt=%0b err=%0b",
                             n, bif.pc, bif.halt, bif.stack_err, m_pc, m_halt, m_err);
            end
        end
    endtask

    initial begin
        start_n = 1'b0;
        bif.stall = 0; bif.branch = 0; bif.flag = 0; bif.call = 0; bif.ret = 0;
        bif.imm = '0; bif.lut_we = 0; bif.lut_waddr = '0; bif.lut_wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch_rel();
        test_lut_jump();
        test_call_ret();
        test_stack_errors();
        test_halt_stall();
        test_prog1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
